wb_slv_regbank: RTL and testbench

- 16-bit Wishbone slave RAM/register bank that consumes the Wishbone master cycles produced by the PCIe TLP-to-Wishbone bridge. It terminates memory reads and writes that arrive on the bridge's BAR.
- Supports classic single cycles and linear incrementing bursts, with programmable wait states, byte-lane writes and error termination for out-of-range addresses.
- Read data is returned in Wishbone byte order; the bridge performs the PCIe byte swap.

---
 rtl/wb_slv_regbank.sv | 161 ++++++++++++++++
 tb/tb_wb_slv_regbank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slv_regbank.sv
// 16-bit Wishbone slave RAM bank with classic/incrementing-burst support and range-error termination.
// Latency: first ack/err 1+WAIT_STATES cycles after cyc&stb is sampled; burst beats then ack every cycle.
// Backpressure: master throttles a burst by lowering wb_stb_i; dropping wb_cyc_i aborts with no ack or write.
module wb_slv_regbank #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic        wb_clk,
    input  logic        rstn,
    input  logic [31:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    input  logic [2:0]  wb_cti_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [15:0] acc_cnt
);

    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS      = 4'(WAIT_STATES);
    localparam bit         NO_WAIT = (WAIT_STATES == 0);
    localparam logic [2:0] CTI_INC = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CLASSIC_ACK,
        S_BURST
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_cnt;      // word address of the next beat
    logic                    upper_nz;      // captured address lies outside the bank
    logic                    is_burst;      // captured cycle type was an incrementing burst
    logic [3:0]              wait_cnt;
    logic [15:0]             ram [DEPTH];

    logic                    start;
    logic [ADDR_WIDTH-1:0]   adr_word;
    logic                    adr_oor;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    cur_oor;
    logic                    beat;          // a termination (ack or err) is issued at this edge
    logic                    ack_d;
    logic                    err_d;
    logic                    wr_en;
    logic                    unused_adr0;

    assign start       = wb_cyc_i & wb_stb_i;
    assign adr_word    = wb_adr_i[ADDR_WIDTH:1];
    assign adr_oor     = |wb_adr_i[31:ADDR_WIDTH+1];
    // Byte-offset bit is meaningless for a 16-bit bank.
    assign unused_adr0 = wb_adr_i[0];

    // Next-state and termination decode; in IDLE the live bus address is used so a
    // zero-wait access can complete on the very edge that samples it.
    always_comb begin
        state_d  = state_q;
        beat     = 1'b0;
        cur_addr = addr_cnt;
        cur_oor  = upper_nz;
        case (state_q)
            S_IDLE: begin
                cur_addr = adr_word;
                cur_oor  = adr_oor;
                if (start) begin
                    if (NO_WAIT) begin
                        beat = 1'b1;
                        if (wb_cti_i != CTI_INC)
                            state_d = S_CLASSIC_ACK;
                        else
                            state_d = adr_oor ? S_IDLE : S_BURST;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // The first termination goes out on the edge where the counter runs out.
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wait_cnt <= 4'd1 && wb_stb_i) begin
                    beat = 1'b1;
                    if (!is_burst)
                        state_d = S_CLASSIC_ACK;
                    else
                        state_d = upper_nz ? S_IDLE : S_BURST;
                end
            end
            S_CLASSIC_ACK: begin
                // Ack cycle: strobe is ignored so ack can never be asserted twice in a row.
                state_d = S_IDLE;
            end
            S_BURST: begin
                // Staying here means the previous beat was tagged incrementing.
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wb_stb_i) begin
                    beat = 1'b1;
                    if (upper_nz || wb_cti_i != CTI_INC)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ack_d = beat & ~cur_oor;
        err_d = beat & cur_oor;
        wr_en = ack_d & wb_we_i;
    end

    // Control state, registered terminations, read data and beat counter.
    always_ff @(posedge wb_clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            addr_cnt <= '0;
            upper_nz <= 1'b0;
            is_burst <= 1'b0;
            wait_cnt <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 16'd0;
            acc_cnt  <= 16'd0;
        end else begin
            state_q  <= state_d;
            wb_ack_o <= ack_d;
            wb_err_o <= err_d;
            // Data bus is only driven for read acks; writes and errors return zero.
            wb_dat_o <= (ack_d && !wb_we_i) ? ram[cur_addr] : 16'd0;
            if (ack_d)
                acc_cnt <= acc_cnt + 16'd1;
            if (beat)
                addr_cnt <= cur_addr + 1'b1;
            else if (state_q == S_IDLE && start)
                addr_cnt <= adr_word;
            if (state_q == S_IDLE && start) begin
                upper_nz <= adr_oor;
                is_burst <= (wb_cti_i == CTI_INC);
                wait_cnt <= WS;
            end else if (state_q == S_WAIT && wait_cnt > 4'd1) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Storage: contents survive reset, but no write may land while reset is held.
    always_ff @(posedge wb_clk or negedge rstn) begin
        if (!rstn) begin
            // contents intentionally retained
        end else if (wr_en) begin
            if (wb_sel_i[1])
                ram[cur_addr][15:8] <= wb_dat_i[15:8];
            if (wb_sel_i[0])
                ram[cur_addr][7:0] <= wb_dat_i[7:0];
        end
    end

endmodule

// File: tb/tb_wb_slv_regbank.sv
// Randomised scoreboard bench for wb_slv_regbank: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever the slave terminates a beat.
// A second instance with three wait states checks first-ack latency and pulse width.
module tb_wb_slv_regbank;

    logic        wb_clk;
    logic        rstn;
    logic [31:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [2:0]  wb_cti_i;
    logic        wb_we_i;
    logic [1:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [15:0] acc_cnt;

    logic [31:0] w3_adr;
    logic [15:0] w3_dat_i;
    logic        w3_we;
    logic        w3_stb;
    logic        w3_cyc;
    logic [15:0] w3_dat_o;
    logic        w3_ack;
    logic        w3_err;
    logic [15:0] w3_acc;

    wb_slv_regbank #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut (
        .wb_clk(wb_clk), .rstn(rstn), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_cti_i(wb_cti_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .acc_cnt(acc_cnt)
    );

    wb_slv_regbank #(.ADDR_WIDTH(8), .WAIT_STATES(3)) dut_ws3 (
        .wb_clk(wb_clk), .rstn(rstn), .wb_adr_i(w3_adr), .wb_dat_i(w3_dat_i),
        .wb_cti_i(3'b000), .wb_we_i(w3_we), .wb_sel_i(2'b11), .wb_stb_i(w3_stb),
        .wb_cyc_i(w3_cyc), .wb_dat_o(w3_dat_o), .wb_ack_o(w3_ack), .wb_err_o(w3_err),
        .acc_cnt(w3_acc)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic        err;
        logic        chk_dat;
        logic [15:0] dat;
        logic [15:0] acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] mem [256];      // reference memory image
    logic [15:0] acc_m;          // reference ack count
    logic [15:0] bdat [256];     // burst payload
    int          n_chk;
    int          n_pass;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: predicts one beat's response and applies its effect.
    task automatic push_beat(input bit we, input bit oor, input int idx,
                             input logic [15:0] d, input logic [1:0] sel);
        exp_t e;
        e.err     = oor;
        e.chk_dat = oor || !we;
        e.dat     = (oor || we) ? 16'h0000 : mem[idx];
        if (!oor) begin
            acc_m = acc_m + 16'd1;
            if (we && sel[1]) mem[idx][15:8] = d[15:8];
            if (we && sel[0]) mem[idx][7:0]  = d[7:0];
        end
        e.acc = acc_m;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 64; i++) begin
            @(posedge wb_clk); #1;
            if (wb_ack_o || wb_err_o) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic classic(input bit we, input logic [31:0] adr, input logic [15:0] d,
                           input logic [1:0] sel, input int exp_lat, input bit hold);
        int c;
        push_beat(we, |adr[31:9], int'(adr[8:1]), d, sel);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
        wb_dat_i = d; wb_sel_i = sel; wb_cti_i = 3'b000;
        wait_resp(c);
        chk("classic_latency", c, exp_lat);
        if (!hold) begin
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            @(posedge wb_clk); #1;
        end
    endtask

    task automatic burst(input bit we, input logic [31:0] adr, input int n,
                         input int gap_after, input int drop_after);
        int c;
        bit oor;
        oor = |adr[31:9];
        for (int k = 0; k < n; k++) begin
            push_beat(we, oor, (int'(adr[8:1]) + k) % 256, bdat[k], 2'b11);
            wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
            wb_sel_i = 2'b11; wb_dat_i = bdat[k];
            wb_cti_i = (k == n - 1) ? 3'b111 : 3'b010;
            wait_resp(c);
            chk("burst_beat_latency", c, 1);
            if (oor || c < 0 || k == drop_after - 1) break;
            if (k == gap_after) begin
                wb_stb_i = 1'b0;
                @(posedge wb_clk); #1;
                @(posedge wb_clk); #1;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b000;
        @(posedge wb_clk); #1;
    endtask

    task automatic w3_xfer(input bit we, input logic [31:0] adr, input logic [15:0] d,
                           output int lat, output logic [15:0] rd);
        lat = -1;
        rd  = 16'h0000;
        w3_cyc = 1'b1; w3_stb = 1'b1; w3_we = we; w3_adr = adr; w3_dat_i = d;
        for (int i = 1; i <= 64; i++) begin
            @(posedge wb_clk); #1;
            if (w3_ack || w3_err) begin
                lat = i;
                rd  = w3_dat_o;
                break;
            end
        end
        w3_cyc = 1'b0; w3_stb = 1'b0;
    endtask

    // Monitor: every termination must match the oldest prediction.
    always @(negedge wb_clk) begin
        if (rstn) begin
            if (wb_ack_o || wb_err_o) begin
                chk("ack_err_exclusive", {31'd0, wb_ack_o & wb_err_o}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_termination", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_is_err", {31'd0, wb_err_o}, {31'd0, mon_e.err});
                    if (mon_e.chk_dat) chk("resp_data", {16'd0, wb_dat_o}, {16'd0, mon_e.dat});
                    chk("acc_cnt", {16'd0, acc_cnt}, {16'd0, mon_e.acc});
                end
            end else begin
                chk("dat_idle_zero", {16'd0, wb_dat_o}, 32'd0);
            end
        end
    end

    initial begin
        int          c;
        int          lat;
        logic [15:0] rd;
        logic [31:0] adr;
        n_chk = 0; n_pass = 0; acc_m = 16'd0;
        rstn = 1'b0;
        wb_adr_i = 0; wb_dat_i = 0; wb_cti_i = 0; wb_we_i = 0; wb_sel_i = 0;
        wb_stb_i = 0; wb_cyc_i = 0;
        w3_adr = 0; w3_dat_i = 0; w3_we = 0; w3_stb = 0; w3_cyc = 0;
        repeat (3) @(posedge wb_clk);
        #1;
        chk("reset_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("reset_err", {31'd0, wb_err_o}, 32'd0);
        chk("reset_dat", {16'd0, wb_dat_o}, 32'd0);
        chk("reset_acc", {16'd0, acc_cnt}, 32'd0);
        rstn = 1'b1;
        @(posedge wb_clk); #1;

        // Classic write then read, then back-to-back reads (ack every 2nd cycle).
        classic(1, 32'h4, 16'h1234, 2'b11, 1, 0);
        classic(0, 32'h4, 16'h0000, 2'b11, 1, 0);
        classic(0, 32'h4, 16'h0000, 2'b11, 1, 1);
        classic(0, 32'h4, 16'h0000, 2'b11, 2, 0);

        // Byte lanes and empty-select write.
        classic(1, 32'h6, 16'hAAAA, 2'b11, 1, 0);
        classic(1, 32'h6, 16'h55FF, 2'b01, 1, 0);
        classic(0, 32'h6, 16'h0000, 2'b11, 1, 0);
        classic(1, 32'h6, 16'h9999, 2'b00, 1, 0);
        classic(0, 32'h6, 16'h0000, 2'b11, 1, 0);

        // Fill the whole bank so every later read has a known value.
        for (int i = 0; i < 256; i++) bdat[i] = 16'($urandom);
        burst(1, 32'h0, 256, -1, -1);

        // Four-beat burst write/read at word 8.
        for (int i = 0; i < 4; i++) bdat[i] = 16'(i + 1);
        burst(1, 32'h10, 4, -1, -1);
        burst(0, 32'h10, 4, -1, -1);

        // Stalled burst: gap after beat 2, cyc dropped after beat 3.
        for (int i = 0; i < 4; i++) bdat[i] = 16'hC0 + 16'(i);
        burst(1, 32'h10, 4, 1, 3);
        classic(0, 32'h14, 16'h0, 2'b11, 1, 0);
        classic(0, 32'h16, 16'h0, 2'b11, 1, 0);

        // Out-of-range classic and burst, then confirm word 0 untouched.
        classic(1, 32'h0001_0000, 16'h7777, 2'b11, 1, 0);
        classic(0, 32'h0001_0000, 16'h0000, 2'b11, 1, 0);
        burst(1, 32'h0002_0000, 3, -1, -1);
        classic(0, 32'h0, 16'h0, 2'b11, 1, 0);

        // Randomised traffic, including address wrap and out-of-range hits.
        for (int it = 0; it < 40; it++) begin
            adr = {23'd0, 8'($urandom_range(0, 255)), 1'($urandom)};
            if ($urandom_range(0, 9) == 0) adr[31:9] = 23'($urandom_range(1, 8388607));
            for (int i = 0; i < 8; i++) bdat[i] = 16'($urandom);
            case ($urandom_range(0, 3))
                0: classic(1, adr, bdat[0], 2'($urandom_range(0, 3)), 1, 0);
                1: classic(0, adr, 16'h0, 2'b11, 1, 0);
                2: burst(1, adr, $urandom_range(1, 8), -1, -1);
                default: burst(0, adr, $urandom_range(1, 8), -1, -1);
            endcase
        end

        // Reset asserted in the middle of a burst write.
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_sel_i = 2'b11; wb_cti_i = 3'b010;
        wb_adr_i = 32'h50; wb_dat_i = 16'hBEEF;
        push_beat(1, 0, 40, 16'hBEEF, 2'b11);
        wait_resp(c);
        chk("rst_burst_beat0", c, 1);
        wb_dat_i = 16'hCAFE;
        push_beat(1, 0, 41, 16'hCAFE, 2'b11);
        wait_resp(c);
        chk("rst_burst_beat1", c, 1);
        wb_dat_i = 16'hDEAD;
        #2 rstn = 1'b0;
        #1;
        chk("midrst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("midrst_err", {31'd0, wb_err_o}, 32'd0);
        chk("midrst_dat", {16'd0, wb_dat_o}, 32'd0);
        chk("midrst_acc", {16'd0, acc_cnt}, 32'd0);
        @(posedge wb_clk); #1;
        wb_cyc_i = 0; wb_stb_i = 0; wb_cti_i = 3'b000;
        exp_q.delete();
        acc_m = 16'd0;
        rstn = 1'b1;
        @(posedge wb_clk); #1;
        classic(0, 32'h52, 16'h0, 2'b11, 1, 0);
        classic(0, 32'h54, 16'h0, 2'b11, 1, 0);

        // Three-wait-state instance: latency and single-cycle ack.
        w3_xfer(1, 32'hA, 16'h1234, lat, rd);
        chk("ws3_write_latency", lat, 4);
        @(posedge wb_clk); #1;
        chk("ws3_ack_one_cycle", {31'd0, w3_ack}, 32'd0);
        w3_xfer(0, 32'hA, 16'h0000, lat, rd);
        chk("ws3_read_latency", lat, 4);
        chk("ws3_read_data", {16'd0, rd}, 32'h1234);
        @(posedge wb_clk); #1;
        chk("ws3_acc_cnt", {16'd0, w3_acc}, 32'd2);

        repeat (3) @(posedge wb_clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
